mips_dmem_io: RTL

Data-side memory responder for the single-cycle MIPS core: it sits on the far end of the core's `memwrite` / `aluout` / `writedata` / `readdata` interface. It provides a word-addressed data RAM and a small memory-mapped I/O page holding a free-running cycle counter and a byte-wide transmit FIFO. The FIFO drains through a valid/ready stream port toward an external sink. Reads are combinational, so a load completes in the core's single cycle; all state changes on the rising clock edge.

---
 rtl/mips_dmem_io.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mips_dmem_io.sv
// mips_dmem_io
// Data-side memory responder for the single-cycle MIPS core. It decodes the
// core's byte address into three regions:
//   - word-addressed data RAM (addr[31:28] == 0, upper index bits alias)
//   - CYCLE  (FFFF_0000): free-running 32-bit cycle counter, loadable
//   - TXDATA (FFFF_0004): push a byte into the TX FIFO / peek the head
//   - STATUS (FFFF_0008): {count, 0, ovf, full, empty}, write bit 2 clears ovf
// Unmapped addresses read 0 and ignore writes. Loads are combinational.
//
// Ports
//   clk        sole clock, rising edge
//   reset_n    asynchronous active-low reset
//   memwrite   store strobe from the core
//   addr       byte address (core ALU output); addr[1:0] ignored
//   writedata  store data
//   readdata   load data, combinational from addr
//   out_valid  TX FIFO head valid
//   out_data   TX FIFO head byte (registered storage at the read pointer)
//   out_ready  sink accepts the head this cycle

module mips_dmem_io #(
  parameter int MEM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Word addresses (addr[31:2]) of the I/O registers.
  localparam logic [29:0] CYCLE_WA  = 30'h3FFF_C000;
  localparam logic [29:0] TXDATA_WA = 30'h3FFF_C001;
  localparam logic [29:0] STATUS_WA = 30'h3FFF_C002;

  // Address decode
  logic sel_ram;
  logic sel_cycle;
  logic sel_tx;
  logic sel_status;
  logic [AW-1:0] ram_idx;

  assign sel_ram    = (addr[31:28] == 4'h0);
  assign sel_cycle  = (addr[31:2] == CYCLE_WA);
  assign sel_tx     = (addr[31:2] == TXDATA_WA);
  assign sel_status = (addr[31:2] == STATUS_WA);
  assign ram_idx    = addr[AW+1:2];

  // Byte offset within the word plays no part in decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  // Data RAM: no reset, full-word stores only.
  logic [31:0] ram [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (memwrite && sel_ram) begin
      ram[ram_idx] <= writedata;
    end
  end

  // Cycle counter and TX FIFO state
  logic [31:0]   cycle;
  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          ovf;

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic push_ok;

  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_DEPTH));
  // Handshake is qualified only by registered state, so there is no path
  // from out_ready to out_valid or readdata.
  assign pop     = !empty && out_ready;
  assign push    = memwrite && sel_tx;
  // A simultaneous pop frees the slot the push needs.
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo[i] <= '0;
      end
    end else begin
      // Load wins over increment so the next read returns writedata exactly.
      if (memwrite && sel_cycle) begin
        cycle <= writedata;
      end else begin
        cycle <= cycle + 32'd1;
      end

      if (push_ok) begin
        fifo[wr_ptr] <= writedata[7:0];
        wr_ptr       <= wr_ptr + 1'b1;
      end

      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Set and clear target different addresses, so they never collide.
      if (push && full && !pop) begin
        ovf <= 1'b1;
      end else if (memwrite && sel_status && writedata[2]) begin
        ovf <= 1'b0;
      end
    end
  end

  assign out_valid = !empty;
  assign out_data  = fifo[rd_ptr];

  // Load path
  logic [3:0] count4;
  assign count4 = 4'(count);

  always_comb begin
    readdata = '0;
    if (sel_ram) begin
      readdata = ram[ram_idx];
    end else if (sel_cycle) begin
      readdata = cycle;
    end else if (sel_tx) begin
      readdata = empty ? 32'h0 : {24'h0, out_data};
    end else if (sel_status) begin
      readdata = {24'h0, count4, 1'b0, ovf, full, empty};
    end
  end

endmodule
